// File: rtl/acidpro_sequencer_if.sv
// Host-side control/status bundle for the purification protocol sequencer.
// The host (master) drives the run request and latched configuration; the sequencer (slave) reports progress.
interface acidpro_sequencer_if #(
  parameter int N_CH     = 3,
  parameter int STROKE_W = 8
);
  logic                start;
  logic                abort;
  logic [N_CH-1:0]     ch_mask;
  logic [STROKE_W-1:0] load_strokes;
  logic [STROKE_W-1:0] lysis_strokes;
  logic [STROKE_W-1:0] wash_strokes;
  logic [STROKE_W-1:0] elute_strokes;
  logic [STROKE_W-1:0] collect_strokes;
  logic                busy;
  logic                done;
  logic                aborted;
  logic [2:0]          phase;
  logic [STROKE_W-1:0] stroke_cnt;

  modport master (
    output start, abort, ch_mask, load_strokes, lysis_strokes, wash_strokes,
           elute_strokes, collect_strokes,
    input  busy, done, aborted, phase, stroke_cnt
  );

  modport slave (
    input  start, abort, ch_mask, load_strokes, lysis_strokes, wash_strokes,
           elute_strokes, collect_strokes,
    output busy, done, aborted, phase, stroke_cnt
  );
endinterface

// File: rtl/acidpro_sequencer.sv
// Valve and pump sequencer for N_CH purification chambers sharing one reagent junction.
// All control lines are registered; a line at 1 is pressurised (valve closed).
//
// state   | meaning
// IDLE    | waiting for start with a non-zero chamber mask
// LOAD    | sample drawn in through horizontal line into enabled chambers
// LYSIS   | lysis reagent pumped through enabled chambers
// WASH    | wash reagent pumped, beads trapped, effluent to waste
// ELUTE   | elution reagent pumped over trapped beads
// COLLECT | enabled chambers emptied one at a time, ascending index
// DONE    | one-cycle completion pulse
module acidpro_sequencer #(
  parameter int N_CH     = 3,
  parameter int STROKE_W = 8,
  parameter int PUMP_DIV = 4
) (
  input  logic                clk,
  input  logic                rst,
  acidpro_sequencer_if.slave  host,
  output logic                lysis_ctl,
  output logic                wash_ctl,
  output logic                elute_ctl,
  output logic                horiz_ctl,
  output logic                loop_exit_ctl,
  output logic                bead_vtl_ctl,
  output logic                bead_trap_ctl,
  output logic                waste_ctl,
  output logic [N_CH-1:0]     vertical_ctl,
  output logic [N_CH-1:0]     collection_ctl,
  output logic [2:0]          pump_ctl
);
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int DIV_W = (PUMP_DIV > 1) ? $clog2(PUMP_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(PUMP_DIV - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0, LOAD = 3'd1, LYSIS = 3'd2, WASH = 3'd3,
    ELUTE = 3'd4, COLLECT = 3'd5, DONE = 3'd6
  } state_t;

  typedef struct packed {
    logic [N_CH-1:0]     mask;
    logic [STROKE_W-1:0] load;
    logic [STROKE_W-1:0] lysis;
    logic [STROKE_W-1:0] wash;
    logic [STROKE_W-1:0] elute;
    logic [STROKE_W-1:0] collect;
  } cfg_t;

  state_t              state, state_nx;
  cfg_t                cfg, cfg_nx;
  logic [DIV_W-1:0]    div_cnt, div_nx;
  logic [1:0]          pump_ph, pph_nx;
  logic [STROKE_W-1:0] scnt, scnt_nx, scnt_inc, cur_strk, nx_strk;
  logic [CH_W-1:0]     chan, chan_nx;
  logic                adv;
  int                  nxt_ch, first_ch;

  logic                busy_nx, done_nx, aborted_nx;
  logic                lysis_nx, wash_nx, elute_nx, horiz_nx, loop_exit_nx;
  logic                bead_trap_nx, waste_nx;
  logic [N_CH-1:0]     vert_nx, coll_nx;
  logic [2:0]          pump_nx;

  function automatic logic [STROKE_W-1:0] strokes_of(input state_t s, input cfg_t c);
    case (s)
      LOAD:    return c.load;
      LYSIS:   return c.lysis;
      WASH:    return c.wash;
      ELUTE:   return c.elute;
      COLLECT: return c.collect;
      default: return '0;
    endcase
  endfunction

  // Lowest enabled chamber at or above 'from', or -1 when none remain.
  function automatic int find_en(input logic [N_CH-1:0] m, input int from);
    int r;
    r = -1;
    for (int i = N_CH - 1; i >= 0; i--)
      if (i >= from && m[i]) r = i;
    return r;
  endfunction

  assign cur_strk = strokes_of(state, cfg);
  assign scnt_inc = scnt + 1'b1;
  assign nxt_ch   = find_en(cfg.mask, int'(chan) + 1);
  assign first_ch = find_en(cfg.mask, 0);

  always_comb begin
    state_nx   = state;
    cfg_nx     = cfg;
    div_nx     = div_cnt;
    pph_nx     = pump_ph;
    scnt_nx    = scnt;
    chan_nx    = chan;
    adv        = 1'b0;
    aborted_nx = 1'b0;

    case (state)
      IDLE: begin
        if (host.start && host.ch_mask != '0) begin
          cfg_nx   = '{mask: host.ch_mask, load: host.load_strokes,
                       lysis: host.lysis_strokes, wash: host.wash_strokes,
                       elute: host.elute_strokes, collect: host.collect_strokes};
          state_nx = LOAD;
          div_nx   = DIV_MAX;
          pph_nx   = 2'd0;
          scnt_nx  = '0;
        end
      end
      DONE: state_nx = IDLE;
      default: begin
        if (cur_strk == '0) begin
          adv = 1'b1;
        end else if (div_cnt == '0) begin
          if (pump_ph == 2'd2) begin
            if (scnt_inc == cur_strk) begin
              adv = 1'b1;
            end else begin
              scnt_nx = scnt_inc;
              pph_nx  = 2'd0;
              div_nx  = DIV_MAX;
            end
          end else begin
            pph_nx = pump_ph + 2'd1;
            div_nx = DIV_MAX;
          end
        end else begin
          div_nx = div_cnt - 1'b1;
        end
      end
    endcase

    if (adv) begin
      scnt_nx = '0;
      pph_nx  = 2'd0;
      div_nx  = DIV_MAX;
      case (state)
        LOAD:  state_nx = LYSIS;
        LYSIS: state_nx = WASH;
        WASH:  state_nx = ELUTE;
        ELUTE: begin
          state_nx = COLLECT;
          chan_nx  = CH_W'(first_ch);
        end
        default: begin
          if (cur_strk != '0 && nxt_ch >= 0) chan_nx = CH_W'(nxt_ch);
          else state_nx = DONE;
        end
      endcase
    end

    if (host.abort && state != IDLE) begin
      state_nx   = IDLE;
      scnt_nx    = '0;
      pph_nx     = 2'd0;
      div_nx     = DIV_MAX;
      aborted_nx = 1'b1;
    end
  end

  // Output decode works on next-state values so every line comes straight from a flop.
  always_comb begin
    busy_nx      = (state_nx != IDLE);
    done_nx      = (state_nx == DONE);
    lysis_nx     = 1'b1;
    wash_nx      = 1'b1;
    elute_nx     = 1'b1;
    horiz_nx     = 1'b1;
    loop_exit_nx = 1'b1;
    bead_trap_nx = 1'b1;
    waste_nx     = 1'b1;
    vert_nx      = '1;
    coll_nx      = '1;
    pump_nx      = 3'b111;
    nx_strk      = strokes_of(state_nx, cfg_nx);

    if (state_nx inside {LOAD, LYSIS, WASH, ELUTE, COLLECT} && nx_strk != '0) begin
      case (pph_nx)
        2'd0:    pump_nx = 3'b110;
        2'd1:    pump_nx = 3'b101;
        default: pump_nx = 3'b011;
      endcase
    end

    case (state_nx)
      LOAD: begin
        vert_nx  = ~cfg_nx.mask;
        horiz_nx = 1'b0;
      end
      LYSIS: begin
        lysis_nx     = 1'b0;
        vert_nx      = ~cfg_nx.mask;
        loop_exit_nx = 1'b0;
      end
      WASH: begin
        wash_nx      = 1'b0;
        vert_nx      = ~cfg_nx.mask;
        loop_exit_nx = 1'b0;
        bead_trap_nx = 1'b0;
        waste_nx     = 1'b0;
      end
      ELUTE: begin
        elute_nx     = 1'b0;
        vert_nx      = ~cfg_nx.mask;
        loop_exit_nx = 1'b0;
        bead_trap_nx = 1'b0;
      end
      COLLECT: begin
        bead_trap_nx = 1'b0;
        for (int i = 0; i < N_CH; i++)
          if (CH_W'(i) == chan_nx) coll_nx[i] = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cfg            <= '0;
      div_cnt        <= '0;
      pump_ph        <= 2'd0;
      scnt           <= '0;
      chan           <= '0;
      host.busy      <= 1'b0;
      host.done      <= 1'b0;
      host.aborted   <= 1'b0;
      lysis_ctl      <= 1'b1;
      wash_ctl       <= 1'b1;
      elute_ctl      <= 1'b1;
      horiz_ctl      <= 1'b1;
      loop_exit_ctl  <= 1'b1;
      bead_vtl_ctl   <= 1'b1;
      bead_trap_ctl  <= 1'b1;
      waste_ctl      <= 1'b1;
      vertical_ctl   <= '1;
      collection_ctl <= '1;
      pump_ctl       <= 3'b111;
    end else begin
      state          <= state_nx;
      cfg            <= cfg_nx;
      div_cnt        <= div_nx;
      pump_ph        <= pph_nx;
      scnt           <= scnt_nx;
      chan           <= chan_nx;
      host.busy      <= busy_nx;
      host.done      <= done_nx;
      host.aborted   <= aborted_nx;
      lysis_ctl      <= lysis_nx;
      wash_ctl       <= wash_nx;
      elute_ctl      <= elute_nx;
      horiz_ctl      <= horiz_nx;
      loop_exit_ctl  <= loop_exit_nx;
      bead_vtl_ctl   <= 1'b1;
      bead_trap_ctl  <= bead_trap_nx;
      waste_ctl      <= waste_nx;
      vertical_ctl   <= vert_nx;
      collection_ctl <= coll_nx;
      pump_ctl       <= pump_nx;
    end
  end

  assign host.phase      = state;
  assign host.stroke_cnt = scnt;
endmodule

// File: tb/tb_acidpro_sequencer.sv
// Directed bench: a PUMP_DIV=2 instance for protocol timing/abort/reset, a PUMP_DIV=1 instance for pump pattern and zero-stroke steps.
module tb_acidpro_sequencer;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  acidpro_sequencer_if #(.N_CH(3), .STROKE_W(8)) ha ();
  acidpro_sequencer_if #(.N_CH(3), .STROKE_W(8)) hb ();

  logic a_lysis, a_wash, a_elute, a_horiz, a_loop, a_bvtl, a_btrap, a_waste;
  logic [2:0] a_vert, a_coll, a_pump;
  logic b_lysis, b_wash, b_elute, b_horiz, b_loop, b_bvtl, b_btrap, b_waste;
  logic [2:0] b_vert, b_coll, b_pump;

  acidpro_sequencer #(.N_CH(3), .STROKE_W(8), .PUMP_DIV(2)) dut_a (
    .clk(clk), .rst(rst), .host(ha.slave),
    .lysis_ctl(a_lysis), .wash_ctl(a_wash), .elute_ctl(a_elute), .horiz_ctl(a_horiz),
    .loop_exit_ctl(a_loop), .bead_vtl_ctl(a_bvtl), .bead_trap_ctl(a_btrap),
    .waste_ctl(a_waste), .vertical_ctl(a_vert), .collection_ctl(a_coll), .pump_ctl(a_pump)
  );

  acidpro_sequencer #(.N_CH(3), .STROKE_W(8), .PUMP_DIV(1)) dut_b (
    .clk(clk), .rst(rst), .host(hb.slave),
    .lysis_ctl(b_lysis), .wash_ctl(b_wash), .elute_ctl(b_elute), .horiz_ctl(b_horiz),
    .loop_exit_ctl(b_loop), .bead_vtl_ctl(b_bvtl), .bead_trap_ctl(b_btrap),
    .waste_ctl(b_waste), .vertical_ctl(b_vert), .collection_ctl(b_coll), .pump_ctl(b_pump)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    ha.start = 0; ha.abort = 0; ha.ch_mask = '0;
    ha.load_strokes = 0; ha.lysis_strokes = 0; ha.wash_strokes = 0;
    ha.elute_strokes = 0; ha.collect_strokes = 0;
    hb.start = 0; hb.abort = 0; hb.ch_mask = '0;
    hb.load_strokes = 0; hb.lysis_strokes = 0; hb.wash_strokes = 0;
    hb.elute_strokes = 0; hb.collect_strokes = 0;
    cyc(2);
    chk("rst_pump", 32'(a_pump), 32'h7);
    chk("rst_busy", 32'(ha.busy), 32'h0);
    chk("rst_phase", 32'(ha.phase), 32'h0);
    chk("rst_vert", 32'(a_vert), 32'h7);
    chk("rst_coll", 32'(a_coll), 32'h7);
    chk("rst_lysis", 32'(a_lysis), 32'h1);
    chk("rst_bvtl", 32'(a_bvtl), 32'h1);
    chk("rst_b_pump", 32'(b_pump), 32'h7);
    rst = 1'b0;
    cyc(1);

    // start with empty mask is ignored
    ha.start = 1; ha.ch_mask = 3'b000; ha.load_strokes = 2;
    cyc(1);
    ha.start = 0;
    chk("mask0_busy", 32'(ha.busy), 32'h0);
    cyc(1);
    chk("mask0_phase", 32'(ha.phase), 32'h0);

    // full run, PUMP_DIV=2, mask 101, strokes 2/1/1/1/1
    ha.ch_mask = 3'b101; ha.load_strokes = 2; ha.lysis_strokes = 1;
    ha.wash_strokes = 1; ha.elute_strokes = 1; ha.collect_strokes = 1;
    ha.start = 1;
    cyc(1); // t+1
    ha.start = 0;
    chk("run_c1_phase", 32'(ha.phase), 32'h1);
    chk("run_c1_busy", 32'(ha.busy), 32'h1);
    chk("run_c1_vert", 32'(a_vert), 32'h2);
    chk("run_c1_horiz", 32'(a_horiz), 32'h0);
    chk("run_c1_pump", 32'(a_pump), 32'h6);
    chk("run_c1_scnt", 32'(ha.stroke_cnt), 32'h0);
    cyc(1); // t+2
    chk("run_c2_pump", 32'(a_pump), 32'h6);
    cyc(1); // t+3
    chk("run_c3_pump", 32'(a_pump), 32'h5);
    ha.start = 1; ha.ch_mask = 3'b010; ha.load_strokes = 9;
    cyc(1); // t+4
    ha.start = 0;
    cyc(3); // t+7
    chk("run_c7_scnt", 32'(ha.stroke_cnt), 32'h1);
    chk("run_c7_pump", 32'(a_pump), 32'h6);
    cyc(5); // t+12
    chk("run_c12_phase", 32'(ha.phase), 32'h1);
    cyc(1); // t+13
    chk("run_c13_phase", 32'(ha.phase), 32'h2);
    chk("run_c13_lysis", 32'(a_lysis), 32'h0);
    chk("run_c13_loop", 32'(a_loop), 32'h0);
    chk("run_c13_horiz", 32'(a_horiz), 32'h1);
    chk("run_c13_scnt", 32'(ha.stroke_cnt), 32'h0);
    cyc(6); // t+19
    chk("run_c19_phase", 32'(ha.phase), 32'h3);
    chk("run_c19_waste", 32'(a_waste), 32'h0);
    chk("run_c19_btrap", 32'(a_btrap), 32'h0);
    chk("run_c19_vert", 32'(a_vert), 32'h2);
    cyc(6); // t+25
    chk("run_c25_phase", 32'(ha.phase), 32'h4);
    chk("run_c25_elute", 32'(a_elute), 32'h0);
    chk("run_c25_waste", 32'(a_waste), 32'h1);
    cyc(6); // t+31
    chk("run_c31_phase", 32'(ha.phase), 32'h5);
    chk("run_c31_coll", 32'(a_coll), 32'h6);
    chk("run_c31_vert", 32'(a_vert), 32'h7);
    chk("run_c31_btrap", 32'(a_btrap), 32'h0);
    cyc(5); // t+36
    chk("run_c36_coll", 32'(a_coll), 32'h6);
    cyc(1); // t+37
    chk("run_c37_coll", 32'(a_coll), 32'h3);
    cyc(5); // t+42
    chk("run_c42_phase", 32'(ha.phase), 32'h5);
    chk("run_c42_done", 32'(ha.done), 32'h0);
    cyc(1); // t+43
    chk("run_c43_done", 32'(ha.done), 32'h1);
    chk("run_c43_phase", 32'(ha.phase), 32'h6);
    chk("run_c43_busy", 32'(ha.busy), 32'h1);
    chk("run_c43_pump", 32'(a_pump), 32'h7);
    chk("run_c43_coll", 32'(a_coll), 32'h7);
    cyc(1); // t+44
    chk("run_c44_busy", 32'(ha.busy), 32'h0);
    chk("run_c44_done", 32'(ha.done), 32'h0);
    chk("run_c44_phase", 32'(ha.phase), 32'h0);

    // abort during WASH
    ha.ch_mask = 3'b101; ha.load_strokes = 2;
    ha.start = 1;
    cyc(1);
    ha.start = 0;
    cyc(19); // t+20
    chk("abt_wash_phase", 32'(ha.phase), 32'h3);
    ha.abort = 1;
    cyc(1);
    ha.abort = 0;
    chk("abt_phase", 32'(ha.phase), 32'h0);
    chk("abt_busy", 32'(ha.busy), 32'h0);
    chk("abt_pulse", 32'(ha.aborted), 32'h1);
    chk("abt_done", 32'(ha.done), 32'h0);
    chk("abt_waste", 32'(a_waste), 32'h1);
    chk("abt_btrap", 32'(a_btrap), 32'h1);
    chk("abt_vert", 32'(a_vert), 32'h7);
    chk("abt_pump", 32'(a_pump), 32'h7);
    cyc(1);
    chk("abt_pulse_end", 32'(ha.aborted), 32'h0);
    chk("abt_no_done", 32'(ha.done), 32'h0);
    ha.start = 1;
    cyc(1);
    ha.start = 0;
    chk("restart_phase", 32'(ha.phase), 32'h1);
    chk("restart_busy", 32'(ha.busy), 32'h1);

    // reset mid-run for two cycles
    cyc(4);
    rst = 1'b1;
    cyc(2);
    chk("mrst_pump", 32'(a_pump), 32'h7);
    chk("mrst_busy", 32'(ha.busy), 32'h0);
    chk("mrst_phase", 32'(ha.phase), 32'h0);
    chk("mrst_vert", 32'(a_vert), 32'h7);
    chk("mrst_horiz", 32'(a_horiz), 32'h1);
    rst = 1'b0;
    cyc(1);
    chk("mrst_idle_phase", 32'(ha.phase), 32'h0);

    // PUMP_DIV=1: pump pattern and zero-stroke LYSIS/WASH; abort+start together in IDLE
    hb.ch_mask = 3'b001; hb.load_strokes = 3; hb.lysis_strokes = 0;
    hb.wash_strokes = 0; hb.elute_strokes = 1; hb.collect_strokes = 1;
    hb.start = 1; hb.abort = 1;
    cyc(1); // t+1
    hb.start = 0; hb.abort = 0;
    chk("pp_c1_phase", 32'(hb.phase), 32'h1);
    chk("pp_c1_pump", 32'(b_pump), 32'h6);
    chk("pp_c1_abt", 32'(hb.aborted), 32'h0);
    cyc(1);
    chk("pp_c2_pump", 32'(b_pump), 32'h5);
    cyc(1);
    chk("pp_c3_pump", 32'(b_pump), 32'h3);
    chk("pp_c3_scnt", 32'(hb.stroke_cnt), 32'h0);
    cyc(1);
    chk("pp_c4_pump", 32'(b_pump), 32'h6);
    chk("pp_c4_scnt", 32'(hb.stroke_cnt), 32'h1);
    cyc(3);
    chk("pp_c7_scnt", 32'(hb.stroke_cnt), 32'h2);
    cyc(2); // t+9
    chk("pp_c9_pump", 32'(b_pump), 32'h3);
    chk("pp_c9_phase", 32'(hb.phase), 32'h1);
    cyc(1); // t+10
    chk("zs_lysis_phase", 32'(hb.phase), 32'h2);
    chk("zs_lysis_pump", 32'(b_pump), 32'h7);
    chk("zs_lysis_valve", 32'(b_lysis), 32'h0);
    cyc(1); // t+11
    chk("zs_wash_phase", 32'(hb.phase), 32'h3);
    chk("zs_wash_pump", 32'(b_pump), 32'h7);
    chk("zs_wash_valve", 32'(b_wash), 32'h0);
    cyc(1); // t+12
    chk("zs_elute_phase", 32'(hb.phase), 32'h4);
    chk("zs_elute_pump", 32'(b_pump), 32'h6);
    cyc(3); // t+15
    chk("pp_c15_phase", 32'(hb.phase), 32'h5);
    chk("pp_c15_coll", 32'(b_coll), 32'h6);
    cyc(3); // t+18
    chk("pp_c18_done", 32'(hb.done), 32'h1);
    cyc(1); // t+19
    chk("pp_c19_busy", 32'(hb.busy), 32'h0);

    // abort in IDLE does nothing
    hb.abort = 1;
    cyc(1);
    hb.abort = 0;
    chk("idle_abt_pulse", 32'(hb.aborted), 32'h0);
    chk("idle_abt_phase", 32'(hb.phase), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/acidpro_sequencer.md
Name: acidpro_sequencer

Overview:
- Clocked protocol controller for the nucleic-acid purification chip.
- Generates every valve and pump control line for N_CH purification chambers sharing one reagent junction.
- Runs a fixed LOAD → LYSIS → WASH → ELUTE → COLLECT protocol with programmable stroke counts, a per-channel enable mask and serialised per-channel collection.
- Sits between the host register interface and the pneumatic solenoid drivers. Control line = 1 means the line is pressurised and the valve is closed.

Parameters:
- N_CH, 3, number of purification chambers (≥1).
- STROKE_W, 8, width of stroke-count inputs and stroke_cnt.
- PUMP_DIV, 4, clocks per pump phase (≥1); one stroke = 3*PUMP_DIV clocks.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  run request; sampled only in IDLE
- abort  in  1  cancel the run; return to IDLE
- ch_mask  in  N_CH  chamber enable; latched at start
- load_strokes  in  STROKE_W  LOAD stroke count; latched at start
- lysis_strokes  in  STROKE_W  LYSIS stroke count; latched at start
- wash_strokes  in  STROKE_W  WASH stroke count; latched at start
- elute_strokes  in  STROKE_W  ELUTE stroke count; latched at start
- collect_strokes  in  STROKE_W  strokes per enabled chamber in COLLECT; latched at start
- busy  out  1  run in progress (LOAD..DONE)
- done  out  1  one-cycle pulse on completion
- aborted  out  1  one-cycle pulse on abort
- phase  out  3  state code
- stroke_cnt  out  STROKE_W  strokes completed in current state/channel
- lysis_ctl, wash_ctl, elute_ctl  out  1 each  reagent inlet valves
- horiz_ctl, loop_exit_ctl, bead_vtl_ctl, bead_trap_ctl, waste_ctl  out  1 each  shared valves
- vertical_ctl  out  N_CH  per-chamber inlet valves
- collection_ctl  out  N_CH  per-chamber collection valves
- pump_ctl  out  3  peristaltic valves p1,p2,p3 (bit0 = p1)

Behaviour:
- All outputs are registered. Reset (synchronous, overrides start/abort):
  - state IDLE, phase=0
  - all *_ctl = all-ones, pump_ctl=3'b111
  - busy=0, done=0, aborted=0, stroke_cnt=0, latched config=0
- States and phase codes: IDLE=0, LOAD=1, LYSIS=2, WASH=3, ELUTE=4, COLLECT=5, DONE=6.
- IDLE:
  - start=1 with ch_mask≠0 → latch all inputs; enter LOAD next cycle (busy rises then).
  - start with ch_mask=0 is ignored. start in any other state is ignored.
- Pump engine:
  - Active in LOAD..COLLECT. Phase pattern per stroke: 3'b110, 3'b101, 3'b011 (p1 open, then p2, then p3). Each phase is held PUMP_DIV clocks.
  - stroke_cnt increments on the last clock of each stroke. It clears on every state or channel change.
  - pump_ctl=3'b111 in IDLE and DONE.
- Step length: S strokes last exactly S*3*PUMP_DIV cycles. S=0 lasts 1 cycle with pump_ctl=3'b111.
- Valve map (0 = open; every line not listed = 1; vertical_ctl opens only masked chambers, i.e. vertical_ctl = ~mask):
  - LOAD: vertical, horiz open.
  - LYSIS: lysis_ctl, vertical, loop_exit open.
  - WASH: wash_ctl, vertical, loop_exit, bead_trap, waste open.
  - ELUTE: elute_ctl, vertical, loop_exit, bead_trap open.
  - COLLECT: bead_trap and collection_ctl[i] open for current chamber i only; vertical all closed.
- COLLECT sequencing:
  - Chambers served in ascending index order. Disabled chambers are skipped in zero cycles.
  - Each enabled chamber gets collect_strokes strokes, so at most one collection_ctl bit is ever 0.
  - collect_strokes=0 → COLLECT lasts 1 cycle total.
- DONE: lasts 1 cycle with done=1 and busy=1; then IDLE.
- Abort, in any non-IDLE state:
  - Next cycle: IDLE, all valves closed, pump 111, busy=0, aborted=1 for 1 cycle, done never pulses.
  - abort in IDLE has no effect.
  - abort and start in the same IDLE cycle → start wins.
- stroke_cnt saturates only by state change. Counts are latched, so input changes mid-run have no effect.

Test Plan:
- Reset check: assert rst for 2 cycles mid-run → next cycle all *_ctl all-ones, pump_ctl=111, busy=0, phase=0.
- Full run, PUMP_DIV=2, N_CH=3:
  - Stimulus: mask=3'b101, strokes load/lysis/wash/elute/collect = 2/1/1/1/1, start at edge t.
  - LOAD t+1..t+12, LYSIS t+13..18, WASH t+19..24, ELUTE t+25..30.
  - COLLECT t+31..42: collection_ctl=3'b110 for 6 cycles, then 3'b011.
  - done=1 only at t+43; busy=0 at t+44.
- Pump pattern, PUMP_DIV=1: pump_ctl sequence 110,101,011 repeating; stroke_cnt increments every 3rd cycle.
- Zero-stroke steps: lysis=wash=0 → each of LYSIS and WASH lasts exactly 1 cycle with pump_ctl=111.
- Mask=0 start → ignored, busy stays 0. start while busy → no restart, timing unchanged.
- abort during WASH → next cycle IDLE, aborted pulse, all valves closed, no done. New start then accepted normally.
